// File: rtl/bfm_apbslave_ws_pkg.sv
// Shared types and helpers for the wait-state APB3 slave memory model.
package bfm_apbslave_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Right shift turning a byte address into a word address.
  function automatic int unsigned byte_shift(input int unsigned dwidth);
    return clog2(dwidth / 8);
  endfunction

endpackage

// File: rtl/bfm_apbslave_ws_mem.sv
// Single-port word memory with byte enables and registered read.
// APB and backdoor share the port; each source has its own read register.
module bfm_apbslave_ws_mem
  import bfm_apbslave_ws_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_apb_en,
  input  logic                                  i_apb_we,
  input  logic [((DEPTH > 1) ? clog2(DEPTH) : 1)-1:0] i_apb_idx,
  input  logic [DWIDTH/8-1:0]                   i_apb_be,
  input  logic [DWIDTH-1:0]                     i_apb_wdata,
  input  logic                                  i_ext_en,
  input  logic                                  i_ext_we,
  input  logic [((DEPTH > 1) ? clog2(DEPTH) : 1)-1:0] i_ext_idx,
  input  logic [DWIDTH-1:0]                     i_ext_wdata,
  output logic [DWIDTH-1:0]                     o_apb_rdata,
  output logic [DWIDTH-1:0]                     o_ext_rdata
);

  localparam int unsigned IWIDTH = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned BWIDTH = DWIDTH / 8;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_apb_rdata, r_ext_rdata;
  logic              w_en, w_we;
  logic [IWIDTH-1:0] w_idx;
  logic [BWIDTH-1:0] w_be;
  logic [DWIDTH-1:0] w_wdata;

  // The controller never enables both sources in one cycle.
  always_comb begin
    w_en = i_apb_en | i_ext_en;
    if (i_ext_en) begin
      w_we    = i_ext_we;
      w_idx   = i_ext_idx;
      w_be    = '1;
      w_wdata = i_ext_wdata;
    end else begin
      w_we    = i_apb_we;
      w_idx   = i_apb_idx;
      w_be    = i_apb_be;
      w_wdata = i_apb_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_en && w_we) begin
      for (int unsigned b = 0; b < BWIDTH; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  // Read registers hold data for one cycle only, zero otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_apb_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      r_apb_rdata <= (i_apb_en && !i_apb_we) ? r_mem[w_idx] : '0;
      r_ext_rdata <= i_ext_en ? r_mem[w_idx] : '0;
    end
  end

  assign o_apb_rdata = r_apb_rdata;
  assign o_ext_rdata = r_ext_rdata;

endmodule

// File: rtl/bfm_apbslave_ws.sv
// APB3 slave memory model with programmable wait states, error window and backdoor.
// Define BFM_APBSLAVE_PSTRB_EN to add the APB4 PSTRB byte-strobe input.
module bfm_apbslave_ws
  import bfm_apbslave_ws_pkg::*;
#(
  parameter int unsigned AWIDTH   = 10,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WSWIDTH  = 4,
  parameter int unsigned ERR_LO   = 0,
  parameter int unsigned ERR_HI   = 0,
  parameter int unsigned CNTWIDTH = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [AWIDTH-1:0]   PADDR,
  input  logic [DWIDTH-1:0]   PWDATA,
`ifdef BFM_APBSLAVE_PSTRB_EN
  input  logic [DWIDTH/8-1:0] PSTRB,
`endif
  output logic [DWIDTH-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [WSWIDTH-1:0]  WS_CFG,
  input  logic                EXT_REQ,
  input  logic                EXT_WR,
  input  logic [AWIDTH-1:0]   EXT_ADDR,
  input  logic [DWIDTH-1:0]   EXT_WDATA,
  output logic                EXT_GNT,
  output logic [DWIDTH-1:0]   EXT_RDATA,
  output logic [CNTWIDTH-1:0] XFER_CNT,
  output logic                PROT_ERR
);

  localparam int unsigned BWIDTH = DWIDTH / 8;
  localparam int unsigned IWIDTH = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned SHIFT  = byte_shift(DWIDTH);
  localparam int unsigned AW1    = AWIDTH + 1;
  localparam bit          ERR_EN = (ERR_HI >= ERR_LO);

  function automatic logic [IWIDTH-1:0] word_idx(input logic [AWIDTH-1:0] a);
    return IWIDTH'((32'(a) >> SHIFT) % DEPTH);
  endfunction

  // Borrow-bit compares keep the window check free of constant-folded terms.
  function automatic logic in_window(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] lo_d, hi_d;
    lo_d = {1'b0, a} - AW1'(ERR_LO);
    hi_d = AW1'(ERR_HI) - {1'b0, a};
    return ERR_EN && !lo_d[AWIDTH] && !hi_d[AWIDTH];
  endfunction

  state_e              r_state, w_state_nxt;
  logic [IWIDTH-1:0]   r_idx, w_apb_idx;
  logic                r_we, r_err;
  logic [DWIDTH-1:0]   r_wdata;
  logic [BWIDTH-1:0]   r_strb, w_strb;
  logic [WSWIDTH-1:0]  r_cnt;
  logic                r_pready, r_pslverr, r_ext_gnt, r_prot;
  logic [CNTWIDTH-1:0] r_xfer;
  logic                w_setup, w_viol, w_viol_idle;
  logic                w_ld, w_cur_we, w_cur_err, w_done_ok;
  logic                w_apb_rd, w_apb_wr, w_ext_acc;
  logic [DWIDTH-1:0]   w_apb_rdata, w_ext_rdata;

`ifdef BFM_APBSLAVE_PSTRB_EN
  assign w_strb = PSTRB;
`else
  assign w_strb = '1;
`endif

  assign w_setup     = PSEL && !PENABLE;
  assign w_viol      = (r_state != ST_IDLE) && !(PSEL && PENABLE);
  assign w_viol_idle = (r_state == ST_IDLE) && PSEL && PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_setup) w_state_nxt = (WS_CFG == '0) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (w_viol)                     w_state_nxt = ST_IDLE;
        else if (r_cnt == WSWIDTH'(1))  w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read is issued one cycle ahead of DONE so PRDATA lines up with PREADY.
  always_comb begin
    w_ld      = 1'b0;
    w_cur_we  = r_we;
    w_cur_err = r_err;
    w_apb_idx = r_idx;
    w_ext_acc = 1'b0;
    if (r_state == ST_IDLE) begin
      w_ld      = w_setup;
      w_cur_we  = PWRITE;
      w_cur_err = in_window(PADDR);
      w_apb_idx = word_idx(PADDR);
      w_ext_acc = EXT_REQ && !w_setup;
    end
    w_done_ok = (r_state == ST_DONE) && !w_viol;
    w_apb_rd  = (w_state_nxt == ST_DONE) && !w_cur_we && !w_cur_err;
    w_apb_wr  = w_done_ok && r_we && !r_err;
    if (PRESET) begin
      w_apb_rd  = 1'b0;
      w_apb_wr  = 1'b0;
      w_ext_acc = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_ext_gnt <= 1'b0;
      r_xfer    <= '0;
      r_prot    <= 1'b0;
    end else begin
      if (w_ld) begin
        r_idx   <= w_apb_idx;
        r_we    <= PWRITE;
        r_err   <= w_cur_err;
        r_wdata <= PWDATA;
        r_strb  <= w_strb;
        r_cnt   <= WS_CFG;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - WSWIDTH'(1);
      end
      r_pready  <= (w_state_nxt == ST_DONE);
      r_pslverr <= (w_state_nxt == ST_DONE) && w_cur_err;
      r_ext_gnt <= w_ext_acc;
      if (w_done_ok)             r_xfer <= r_xfer + CNTWIDTH'(1);
      if (w_viol || w_viol_idle) r_prot <= 1'b1;
    end
  end

  bfm_apbslave_ws_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk       (PCLK),
    .i_rst       (PRESET),
    .i_apb_en    (w_apb_rd || w_apb_wr),
    .i_apb_we    (w_apb_wr),
    .i_apb_idx   (w_apb_idx),
    .i_apb_be    (r_strb),
    .i_apb_wdata (r_wdata),
    .i_ext_en    (w_ext_acc),
    .i_ext_we    (EXT_WR),
    .i_ext_idx   (word_idx(EXT_ADDR)),
    .i_ext_wdata (EXT_WDATA),
    .o_apb_rdata (w_apb_rdata),
    .o_ext_rdata (w_ext_rdata)
  );

  assign PRDATA    = w_apb_rdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign EXT_GNT   = r_ext_gnt;
  assign EXT_RDATA = w_ext_rdata;
  assign XFER_CNT  = r_xfer;
  assign PROT_ERR  = r_prot;

endmodule

// File: tb/tb_bfm_apbslave_ws.sv
// Bench for bfm_apbslave_ws: directed steps plus random APB/backdoor traffic vs. a word-array model.
module tb_bfm_apbslave_ws;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;

  logic          PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic [3:0]    WS_CFG;
  logic          EXT_REQ, EXT_WR, EXT_GNT;
  logic [AW-1:0] EXT_ADDR;
  logic [DW-1:0] EXT_WDATA, EXT_RDATA;
  logic [15:0]   XFER_CNT;
  logic          PROT_ERR;
`ifdef BFM_APBSLAVE_PSTRB_EN
  logic [3:0]    PSTRB;
`endif

  bfm_apbslave_ws #(
    .AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .WSWIDTH(4),
    .ERR_LO(32'h100), .ERR_HI(32'h1FF), .CNTWIDTH(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef BFM_APBSLAVE_PSTRB_EN
    .PSTRB(PSTRB),
`endif
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .WS_CFG(WS_CFG),
    .EXT_REQ(EXT_REQ), .EXT_WR(EXT_WR), .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA),
    .EXT_GNT(EXT_GNT), .EXT_RDATA(EXT_RDATA), .XFER_CNT(XFER_CNT), .PROT_ERR(PROT_ERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [DEPTH];
  int unsigned mdl_cnt = 0;

  function automatic int unsigned midx(input logic [AW-1:0] a);
    return (32'(a) / 4) % DEPTH;
  endfunction

  function automatic bit in_err(input logic [AW-1:0] a);
    return (a >= 12'h100) && (a <= 12'h1FF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [3:0] rnd_strb();
`ifdef BFM_APBSLAVE_PSTRB_EN
    return 4'($urandom_range(0, 15));
`else
    return 4'hF;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete APB transfer starting with the setup cycle in the current cycle.
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] strb, input int ws);
    logic [31:0] exp_rd;
    bit          err;
    int          lat;
    err    = in_err(a);
    exp_rd = (wr || err) ? 32'd0 : mdl[midx(a)];
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; WS_CFG = 4'(ws);
`ifdef BFM_APBSLAVE_PSTRB_EN
    PSTRB = strb;
`endif
    tick();
    PENABLE = 1'b1;
    WS_CFG  = 4'($urandom_range(0, 15));
    lat = 1;
    while (PREADY !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("apb_latency", 64'(lat), 64'(ws + 1));
    chk("apb_prdata", 64'(PRDATA), 64'(exp_rd));
    chk("apb_pslverr", 64'(PSLVERR), 64'(err));
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    if (wr && !err) mdl[midx(a)] = merge(mdl[midx(a)], wd, strb);
    mdl_cnt = (mdl_cnt + 1) % 65536;
    chk("apb_ready_drop", 64'(PREADY), 64'd0);
    chk("apb_prdata_clear", 64'(PRDATA), 64'd0);
    chk("apb_xfer_cnt", 64'(XFER_CNT), 64'(mdl_cnt));
  endtask

  // Single backdoor access while the APB side is idle.
  task automatic ext(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    logic [31:0] exp_rd;
    exp_rd = mdl[midx(a)];
    EXT_REQ = 1'b1; EXT_WR = wr; EXT_ADDR = a; EXT_WDATA = wd;
    tick();
    EXT_REQ = 1'b0;
    rd = EXT_RDATA;
    chk("ext_gnt", 64'(EXT_GNT), 64'd1);
    chk("ext_rdata", 64'(EXT_RDATA), 64'(exp_rd));
    if (wr) mdl[midx(a)] = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd, old30, nd;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    WS_CFG = '0; EXT_REQ = 1'b0; EXT_WR = 1'b0; EXT_ADDR = '0; EXT_WDATA = '0;
`ifdef BFM_APBSLAVE_PSTRB_EN
    PSTRB = 4'hF;
`endif
    repeat (3) tick();
    chk("rst_pready", 64'(PREADY), 64'd0);
    chk("rst_pslverr", 64'(PSLVERR), 64'd0);
    chk("rst_prdata", 64'(PRDATA), 64'd0);
    chk("rst_ext_gnt", 64'(EXT_GNT), 64'd0);
    chk("rst_xfer", 64'(XFER_CNT), 64'd0);
    chk("rst_prot", 64'(PROT_ERR), 64'd0);
    PRESET = 1'b0;
    tick();

    // Fill memory through a held backdoor request, one word per cycle.
    EXT_REQ = 1'b1; EXT_WR = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      EXT_ADDR  = AW'(i * 4);
      EXT_WDATA = $urandom;
      mdl[i]    = EXT_WDATA;
      tick();
    end
    EXT_REQ = 1'b0;
    chk("prefill_gnt", 64'(EXT_GNT), 64'd1);
    tick();
    chk("prefill_xfer", 64'(XFER_CNT), 64'd0);

    // Zero-wait write then read.
    apb(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0);
    apb(1'b0, 12'h010, 32'h0, 4'hF, 0);
    chk("t1_xfer", 64'(XFER_CNT), 64'd2);

    // Three wait states; WS_CFG is scrambled during waits inside apb().
    apb(1'b0, 12'h020, 32'h0, 4'hF, 3);

    // Error window: write suppressed, read returns zero.
    apb(1'b1, 12'h104, 32'h55, 4'hF, 0);
    apb(1'b0, 12'h104, 32'h0, 4'hF, 1);
    ext(1'b0, 12'h104, 32'h0, rd);
    chk("t3_xfer", 64'(XFER_CNT), 64'd5);

    // Backdoor request held across a 2-wait APB read.
    exp_rd = mdl[midx(12'h040)];
    old30  = mdl[midx(12'h030)];
    nd     = $urandom;
    EXT_REQ = 1'b1; EXT_WR = 1'b1; EXT_ADDR = 12'h030; EXT_WDATA = nd;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h040; WS_CFG = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) PENABLE = 1'b1;
      chk("t4_no_gnt", 64'(EXT_GNT), 64'd0);
      if (k < 3) chk("t4_wait", 64'(PREADY), 64'd0);
      if (k == 3) begin
        chk("t4_ready", 64'(PREADY), 64'd1);
        chk("t4_prdata", 64'(PRDATA), 64'(exp_rd));
      end
      if (k == 4) begin
        PSEL = 1'b0; PENABLE = 1'b0;
      end
    end
    mdl_cnt = (mdl_cnt + 1) % 65536;
    tick();
    chk("t4_gnt1", 64'(EXT_GNT), 64'd1);
    chk("t4_old", 64'(EXT_RDATA), 64'(old30));
    mdl[midx(12'h030)] = nd;
    tick();
    chk("t4_regrant", 64'(EXT_GNT), 64'd1);
    chk("t4_new", 64'(EXT_RDATA), 64'(nd));
    EXT_REQ = 1'b0;
    tick();
    chk("t4_gnt_off", 64'(EXT_GNT), 64'd0);
    chk("t4_xfer", 64'(XFER_CNT), 64'(mdl_cnt));
    apb(1'b0, 12'h030, 32'h0, 4'hF, 1);

    // PSEL dropped during wait states.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h050; PWDATA = $urandom; WS_CFG = 4'd3;
    tick();
    PENABLE = 1'b1;
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    chk("t5_prot", 64'(PROT_ERR), 64'd1);
    chk("t5_ready", 64'(PREADY), 64'd0);
    chk("t5_xfer", 64'(XFER_CNT), 64'(mdl_cnt));
    apb(1'b0, 12'h050, 32'h0, 4'hF, 0);
    chk("t5_prot_sticky", 64'(PROT_ERR), 64'd1);

    // Reset during the DONE cycle of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h060; PWDATA = $urandom; WS_CFG = 4'd2;
    tick();
    PENABLE = 1'b1;
    tick();
    tick();
    chk("t5_done", 64'(PREADY), 64'd1);
    PRESET = 1'b1;
    tick();
    chk("t5r_pready", 64'(PREADY), 64'd0);
    chk("t5r_pslverr", 64'(PSLVERR), 64'd0);
    chk("t5r_prdata", 64'(PRDATA), 64'd0);
    chk("t5r_gnt", 64'(EXT_GNT), 64'd0);
    chk("t5r_erdata", 64'(EXT_RDATA), 64'd0);
    chk("t5r_xfer", 64'(XFER_CNT), 64'd0);
    chk("t5r_prot", 64'(PROT_ERR), 64'd0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    mdl_cnt = 0;
    tick();
    apb(1'b0, 12'h060, 32'h0, 4'hF, 0);

`ifdef BFM_APBSLAVE_PSTRB_EN
    apb(1'b1, 12'h070, 32'h11223344, 4'hF, 0);
    apb(1'b1, 12'h070, 32'hAABBCCDD, 4'b0101, 1);
    apb(1'b0, 12'h070, 32'h0, 4'hF, 0);
    ext(1'b0, 12'h070, 32'h0, rd);
    chk("t6_strobe", 64'(rd), 64'h11BB33DD);
`endif

    // Address 0x400 aliases word 0.
    nd = $urandom;
    apb(1'b1, 12'h400, nd, 4'hF, 0);
    ext(1'b0, 12'h000, 32'h0, rd);
    chk("alias_word0", 64'(rd), 64'(nd));
    apb(1'b0, 12'h000, 32'h0, 4'hF, 2);

    // Random mix of APB transfers and backdoor accesses.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ext(1'($urandom_range(0, 1)), 12'($urandom), $urandom, rd);
      end else begin
        apb(1'($urandom_range(0, 1)), 12'($urandom), $urandom, rnd_strb(),
            int'($urandom_range(0, 4)));
      end
    end
    chk("final_prot", 64'(PROT_ERR), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfm_apbslave_ws.md
Name: bfm_apbslave_ws

Overview:
Parametrised APB3 slave memory model for testbenches, successor to the fixed zero-wait APB slave BFM.
- Adds per-transfer programmable wait states, an address window that returns PSLVERR, and a granted backdoor port.
- Adds a completed-transfer counter and sticky protocol-violation detection.
- Sits on the APB side of the bus-fabric benches as the target of APB master BFMs.

Parameters:
AWIDTH, 10, APB address width (byte address).
DWIDTH, 32, data width; must be 8, 16 or 32.
DEPTH, 256, memory words; word index = (PADDR >> log2(DWIDTH/8)) mod DEPTH.
WSWIDTH, 4, width of the wait-state config input.
ERR_LO, 0, lowest byte address of the error window, inclusive.
ERR_HI, 0, highest byte address of the error window, inclusive. ERR_HI < ERR_LO disables the window.
CNTWIDTH, 16, transfer counter width.

Ports:
PCLK  in  1  clock; all logic on the rising edge.
PRESET  in  1  synchronous, active-high reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PWRITE  in  1  APB direction; 1 = write.
PADDR  in  AWIDTH  APB byte address.
PWDATA  in  DWIDTH  APB write data.
PRDATA  out  DWIDTH  APB read data, registered.
PREADY  out  1  APB ready, registered.
PSLVERR  out  1  APB error, registered.
WS_CFG  in  WSWIDTH  wait states applied to the next transfer; sampled in the setup cycle.
EXT_REQ  in  1  backdoor request.
EXT_WR  in  1  backdoor direction; 1 = write.
EXT_ADDR  in  AWIDTH  backdoor byte address.
EXT_WDATA  in  DWIDTH  backdoor write data.
EXT_GNT  out  1  backdoor grant pulse, one cycle.
EXT_RDATA  out  DWIDTH  backdoor read data; valid with EXT_GNT.
XFER_CNT  out  CNTWIDTH  count of completed APB transfers; wraps at all-ones to zero.
PROT_ERR  out  1  sticky protocol-violation flag.

Behaviour:
Reset:
- Synchronous, active-high. All outputs reset to 0, FSM to IDLE, wait counter to 0.
- Memory contents are not cleared.
- PRESET asserted mid-transfer aborts it: no memory write, no count increment.

FSM states: IDLE, WAIT, DONE.
- IDLE: on PSEL=1 and PENABLE=0 (setup cycle T0), latch PADDR, PWRITE, PWDATA and the error-window hit. Load cnt = WS_CFG. Next state is DONE if WS_CFG = 0, else WAIT.
- WAIT: PREADY = 0. Decrement cnt each cycle; on cnt = 1, go to DONE.
- DONE: PREADY = 1 for exactly one cycle, then IDLE.
- Timing: the completing access cycle is T(1+WS_CFG). Zero wait states gives classic two-cycle APB.

Read:
- PRDATA = mem[idx] (or 0 on an error hit), registered so it is valid in the same cycle PREADY = 1.
- PRDATA returns to 0 the cycle after.

Write:
- Commits at the edge ending the DONE cycle, using the data latched in T0.
- Suppressed on an error hit.

PSLVERR: equals the error-window hit during the DONE cycle only, else 0.

XFER_CNT: increments at the end of every DONE cycle, error transfers included.

Protocol violation (sets PROT_ERR; cleared only by PRESET):
- PSEL drops, or PENABLE is low, during WAIT or DONE. The FSM returns to IDLE with no write and no count.
- PENABLE = 1 with PSEL = 1 while in IDLE. Ignored.

Backdoor:
- Granted only when the FSM is in IDLE and no setup cycle is present that cycle; APB always has priority.
- EXT_GNT pulses the cycle after acceptance, with EXT_RDATA = mem word (pre-write value on a write).
- EXT_REQ held high is re-granted every eligible cycle.
- Backdoor accesses ignore the error window.

Address wrap: indices at or beyond DEPTH alias modulo DEPTH. Example: DEPTH = 256, DWIDTH = 32, PADDR = 0x400 maps to word 0.

Optional Feature:
BFM_APBSLAVE_PSTRB_EN
- Defined: adds input port PSTRB, width DWIDTH/8 (APB4). The write updates only the bytes whose strobe is 1. PSTRB is latched in the setup cycle. Backdoor writes remain full-word.
- Undefined: no PSTRB port; all writes are full-word.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/DONE), a clog2 function, and a constant function for the bytes-per-word shift.
- One sub-module, bfm_apbslave_ws_mem: single-port synchronous word memory with byte enables, registered read, two mux-selected access sources (APB and backdoor).

Test Plan:
1. Reset, WS_CFG = 0; write 0xDEADBEEF to 0x010, then read 0x010. Expect PREADY high in T1 of each transfer, PRDATA = 0xDEADBEEF, PSLVERR = 0, XFER_CNT = 2.
2. WS_CFG = 3; read 0x020. Expect PREADY low for T1–T3 and high in T4; a change of WS_CFG during wait states has no effect.
3. ERR_LO = 0x100, ERR_HI = 0x1FF; write 0x55 to 0x104, then read it. Expect PSLVERR = 1 in the DONE cycles, PRDATA = 0, backdoor read of 0x104 returns the prior value, XFER_CNT += 2.
4. EXT_REQ held during a 2-wait APB transfer. Expect no EXT_GNT until the FSM returns to IDLE; a backdoor write then makes the next APB read return the new data.
5. Drop PSEL during WAIT. Expect PROT_ERR = 1 and no write or count. Then assert PRESET mid-transfer: all outputs 0, PROT_ERR cleared, memory preserved.
6. With BFM_APBSLAVE_PSTRB_EN: write 0xAABBCCDD with PSTRB = 4'b0101 over 0x11223344. Expect a readback of 0x11BB33DD; also check address 0x400 aliases word 0.
